// File: rtl/wrr_packet_arbiter_if.sv
// Request/grant bundle between requesters and the weighted round-robin packet arbiter.
interface wrr_packet_arbiter_if #(
  parameter int unsigned REQUASTERS_QUANT = 8,
  parameter int unsigned WEIGHT_W         = 4
);
  localparam int unsigned IdW = $clog2(REQUASTERS_QUANT);

  logic [REQUASTERS_QUANT-1:0]          req;
  logic [REQUASTERS_QUANT-1:0]          last;
  logic [REQUASTERS_QUANT*WEIGHT_W-1:0] weights;
  logic [REQUASTERS_QUANT-1:0]          grants;
  logic [IdW-1:0]                       gnt_id;
  logic                                 busy;

  modport master (
    output req, last, weights,
    input  grants, gnt_id, busy
  );

  modport slave (
    input  req, last, weights,
    output grants, gnt_id, busy
  );
endinterface

// File: rtl/wrr_packet_arbiter.sv
// Weighted round-robin arbiter that locks ownership for whole packets and grants
// each owner up to its programmed weight of packets per turn.
module wrr_packet_arbiter #(
  parameter int unsigned REQUASTERS_QUANT = 8,
  parameter int unsigned WEIGHT_W         = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  wrr_packet_arbiter_if.slave  bus
);
  localparam int unsigned N   = REQUASTERS_QUANT;
  localparam int unsigned IdW = $clog2(N);

  typedef enum logic {StIdle, StOwn} state_e;

  state_e               state_q, state_d;
  logic [IdW-1:0]       owner_q, owner_d;
  logic [IdW-1:0]       ptr_q, ptr_d;
  logic [WEIGHT_W-1:0]  credit_q, credit_d;
  logic [N-1:0]         grants_q, grants_d;

  logic [IdW-1:0]       rel_ptr;
  logic [IdW-1:0]       scan_start;
  logic [IdW-1:0]       scan_idx;
  logic [N-1:0]         cand;
  logic                 found;
  logic [IdW-1:0]       win;
  logic                 own_req;
  logic                 own_last;
  logic                 release_now;

  // A programmed weight of zero still grants one packet.
  function automatic logic [WEIGHT_W-1:0] load_credit(
    input logic [N*WEIGHT_W-1:0] w,
    input logic [IdW-1:0]        idx
  );
    logic [WEIGHT_W-1:0] f;
    f = w[int'(idx)*WEIGHT_W +: WEIGHT_W];
    return (f == '0) ? WEIGHT_W'(1) : f;
  endfunction

  assign rel_ptr = owner_q + IdW'(1);

  // On release the current owner is masked so others get first pick.
  always_comb begin
    if (state_q == StIdle) begin
      scan_start = ptr_q;
      cand       = bus.req;
    end else begin
      scan_start = rel_ptr;
      cand       = bus.req & ~grants_q;
    end
  end

  always_comb begin
    found    = 1'b0;
    win      = '0;
    scan_idx = '0;
    for (int unsigned i = 0; i < N; i++) begin
      scan_idx = IdW'(int'(scan_start) + int'(i));
      if (!found && cand[scan_idx]) begin
        found = 1'b1;
        win   = scan_idx;
      end
    end
  end

  assign own_req     = bus.req[owner_q];
  assign own_last    = bus.last[owner_q];
  assign release_now = !own_req || (own_last && (credit_q == WEIGHT_W'(1)));

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    ptr_d    = ptr_q;
    credit_d = credit_q;
    grants_d = grants_q;
    case (state_q)
      StIdle: begin
        if (found) begin
          state_d       = StOwn;
          owner_d       = win;
          credit_d      = load_credit(bus.weights, win);
          grants_d      = '0;
          grants_d[win] = 1'b1;
        end
      end
      StOwn: begin
        if (release_now) begin
          ptr_d = rel_ptr;
          if (found) begin
            owner_d       = win;
            credit_d      = load_credit(bus.weights, win);
            grants_d      = '0;
            grants_d[win] = 1'b1;
          end else if (own_req) begin
            // Sole requester left: fresh turn for the same owner.
            credit_d = load_credit(bus.weights, owner_q);
          end else begin
            state_d  = StIdle;
            owner_d  = '0;
            credit_d = '0;
            grants_d = '0;
          end
        end else if (own_last) begin
          credit_d = credit_q - WEIGHT_W'(1);
        end
      end
      default: begin
        state_d  = StIdle;
        owner_d  = '0;
        credit_d = '0;
        grants_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= StIdle;
      owner_q  <= '0;
      ptr_q    <= '0;
      credit_q <= '0;
      grants_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      ptr_q    <= ptr_d;
      credit_q <= credit_d;
      grants_q <= grants_d;
    end
  end

  assign bus.grants = grants_q;
  assign bus.gnt_id = owner_q;
  assign bus.busy   = (state_q == StOwn);

endmodule
